fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage.sv | 126 ++++++++++++
 tb/tb_fetch_stage.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction fetch stage: drives the instruction-memory request, absorbs
// memory wait states and IF/ID stalls, and redirects on taken branches.
// Optional build macro FETCH_PERF_EN adds a saturating 16-bit counter
// (fetch_stall_cycles) of cycles spent waiting, holding or dropping.
module fetch_stage #(
  parameter int unsigned            WIDTH    = 32,
  parameter logic [WIDTH-1:0]       RESET_PC = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             branch_taken,
  input  logic [WIDTH-1:0] branch_target,
  output logic             imem_req,
  output logic [WIDTH-1:0] imem_addr,
  input  logic             imem_ready,
  input  logic [WIDTH-1:0] imem_rdata,
  output logic [WIDTH-1:0] instr,
  output logic [WIDTH-1:0] pc_out,
  output logic             ifid_enable,
  output logic             ifid_flush
`ifdef FETCH_PERF_EN
  ,
  output logic [15:0]      fetch_stall_cycles
`endif
);

  typedef enum logic [1:0] {StFetch, StWait, StHold, StDrop} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] buf_instr_q, buf_instr_d;
  logic [WIDTH-1:0] buf_pc_q, buf_pc_d;

  // Memory request is a pure function of state; suppressed during reset.
  always_comb begin
    imem_req  = !reset && (state_q == StFetch || state_q == StWait);
    imem_addr = pc_q;
  end

  // Next-state and IF/ID controls; memory response is honoured the same cycle.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    buf_instr_d = buf_instr_q;
    buf_pc_d    = buf_pc_q;
    instr       = imem_rdata;
    pc_out      = pc_q;
    ifid_enable = 1'b0;
    ifid_flush  = 1'b0;
    if (reset) begin
      ifid_flush = 1'b1;
    end else if (branch_taken) begin
      // A request still in flight must have its late beat discarded.
      ifid_flush = 1'b1;
      pc_d       = branch_target;
      if (state_q == StDrop || (state_q == StWait && !imem_ready)) begin
        state_d = StDrop;
      end else begin
        state_d = StFetch;
      end
    end else begin
      unique case (state_q)
        StFetch, StWait: begin
          if (imem_ready) begin
            if (!stall) begin
              ifid_enable = 1'b1;
              pc_d        = pc_q + WIDTH'(4);
              state_d     = StFetch;
            end else begin
              buf_instr_d = imem_rdata;
              buf_pc_d    = pc_q;
              state_d     = StHold;
            end
          end else begin
            state_d = StWait;
          end
        end
        StHold: begin
          if (!stall) begin
            instr       = buf_instr_q;
            pc_out      = buf_pc_q;
            ifid_enable = 1'b1;
            pc_d        = pc_q + WIDTH'(4);
            state_d     = StFetch;
          end
        end
        StDrop: begin
          if (imem_ready) state_d = StFetch;
        end
        default: state_d = StFetch;
      endcase
    end
  end

  // State, PC and hold buffer.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StFetch;
      pc_q        <= RESET_PC;
      buf_instr_q <= '0;
      buf_pc_q    <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      buf_instr_q <= buf_instr_d;
      buf_pc_q    <= buf_pc_d;
    end
  end

`ifdef FETCH_PERF_EN
  logic [15:0] stall_cnt_q;

  // Saturating count of cycles not spent in a plain fetch.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
    end else if (state_q != StFetch && stall_cnt_q != 16'hFFFF) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign fetch_stall_cycles = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: the driver computes expected outputs from
// a transaction-level model and queues them; a monitor compares each cycle.
module tb_fetch_stage;

  localparam logic [31:0] RstPc = 32'h0;

  logic        clk = 1'b0;
  logic        reset, stall, branch_taken, imem_ready;
  logic [31:0] branch_target, imem_rdata;
  logic        imem_req, ifid_enable, ifid_flush;
  logic [31:0] imem_addr, instr, pc_out;
`ifdef FETCH_PERF_EN
  logic [15:0] fetch_stall_cycles;
`endif

  fetch_stage #(.WIDTH(32), .RESET_PC(RstPc)) dut (
    .clk                (clk),
    .reset              (reset),
    .stall              (stall),
    .branch_taken       (branch_taken),
    .branch_target      (branch_target),
    .imem_req           (imem_req),
    .imem_addr          (imem_addr),
    .imem_ready         (imem_ready),
    .imem_rdata         (imem_rdata),
    .instr              (instr),
    .pc_out             (pc_out),
    .ifid_enable        (ifid_enable),
    .ifid_flush         (ifid_flush)
`ifdef FETCH_PERF_EN
    ,
    .fetch_stall_cycles (fetch_stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        req;
    logic [31:0] addr;
    logic        en;
    logic        flush;
    logic [31:0] instr;
    logic [31:0] pc;
    int          cnt;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: the fetcher's situation described with plain flags.
  logic [31:0] m_pc = 32'h0;
  logic [31:0] m_buf_instr = 32'h0, m_buf_pc = 32'h0;
  bit          m_waiting = 0;  // a request was issued earlier and is unanswered
  bit          m_holding = 0;  // a fetched instruction is parked during a stall
  bit          m_dropping = 0; // the next returning beat belongs to a dead path
  int          m_cnt = 0;

  task automatic cyc(input logic r, input logic s, input logic b, input logic [31:0] t,
                     input logic rdy, input logic [31:0] d);
    exp_t e;
    @(posedge clk);
    #1;
    reset = r; stall = s; branch_taken = b; branch_target = t;
    imem_ready = rdy; imem_rdata = d;
    e.addr = m_pc; e.en = 0; e.flush = 0; e.instr = 32'h0; e.pc = 32'h0; e.cnt = m_cnt;
    if (r) begin
      e.req = 0; e.flush = 1;
      m_pc = RstPc; m_waiting = 0; m_holding = 0; m_dropping = 0;
      m_buf_instr = 0; m_buf_pc = 0; m_cnt = 0;
    end else begin
      e.req = !m_holding && !m_dropping;
      if ((m_waiting || m_holding || m_dropping) && m_cnt < 65535) m_cnt++;
      if (b) begin
        e.flush = 1;
        if (!m_dropping) m_dropping = m_waiting && !rdy;
        m_pc = t; m_waiting = 0; m_holding = 0;
      end else if (m_dropping) begin
        if (rdy) m_dropping = 0;
      end else if (m_holding) begin
        if (!s) begin
          e.en = 1; e.instr = m_buf_instr; e.pc = m_buf_pc;
          m_pc = m_pc + 32'd4; m_holding = 0;
        end
      end else if (rdy) begin
        m_waiting = 0;
        if (!s) begin
          e.en = 1; e.instr = d; e.pc = m_pc; m_pc = m_pc + 32'd4;
        end else begin
          m_buf_instr = d; m_buf_pc = m_pc; m_holding = 1;
        end
      end else begin
        m_waiting = 1;
      end
    end
    exp_q.push_back(e);
  endtask

  function automatic void chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", nm, got, exp, $time);
    end
  endfunction

  // Monitor: compare every cycle's outputs against the queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("imem_req", {31'h0, imem_req}, {31'h0, e.req});
        chk("ifid_flush", {31'h0, ifid_flush}, {31'h0, e.flush});
        chk("ifid_enable", {31'h0, ifid_enable}, {31'h0, e.en});
        if (e.req) chk("imem_addr", imem_addr, e.addr);
        if (e.en) begin
          chk("instr", instr, e.instr);
          chk("pc_out", pc_out, e.pc);
        end
`ifdef FETCH_PERF_EN
        chk("stall_cycles", {16'h0, fetch_stall_cycles}, e.cnt[31:0]);
`endif
      end
    end
  end

  initial begin
    reset = 1; stall = 0; branch_taken = 0; branch_target = 0;
    imem_ready = 0; imem_rdata = 0;
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 1, 0);
    // Zero-wait memory, one instruction per cycle.
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 1, 32'h1000 + i);
    // Memory wait states at PC=8.
    cyc(0, 0, 1, 32'h8, 1, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, 32'hBAD0 + i);
    cyc(0, 0, 0, 0, 1, 32'h0000_0888);
    // Stall while an instruction returns at PC=4.
    cyc(0, 0, 1, 32'h4, 0, 0);
    cyc(0, 1, 0, 0, 1, 32'hDEAD_BEEF);
    cyc(0, 1, 0, 0, 1, 32'h1111_1111);
    cyc(0, 0, 0, 0, 1, 32'h2222_2222);
    cyc(0, 0, 0, 0, 1, 32'h3333_3333);
    // Branch while waiting; the stale beat must be dropped.
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 32'h100, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 32'h57A1_E000);
    cyc(0, 0, 0, 0, 1, 32'h0000_0100);
    // Branch and stall together while holding.
    cyc(0, 1, 0, 0, 1, 32'hAAAA_5555);
    cyc(0, 1, 1, 32'h200, 1, 32'h0);
    cyc(0, 0, 0, 0, 1, 32'h0000_0200);
    // PC wrap, then reset in the middle of a hold.
    cyc(0, 0, 1, 32'hFFFF_FFFC, 1, 0);
    cyc(0, 0, 0, 0, 1, 32'hFFFF_0001);
    cyc(0, 0, 0, 0, 1, 32'hFFFF_0002);
    cyc(0, 1, 0, 0, 1, 32'hFFFF_0003);
    cyc(1, 1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 32'h0000_0004);
    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(0, 99) < 1, $urandom_range(0, 99) < 30,
          $urandom_range(0, 99) < 10, $urandom & 32'hFFFF_FFFC,
          $urandom_range(0, 99) < 60, $urandom);
    end
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
